// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: widths, arbiter state encodings, master IDs and the
// default watchdog limit. The address decoder imports the same package.
package bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 2;
    localparam int WAIT_W = 8;

    // Granted cycles without a slave ack before the arbiter forces completion.
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        MASTER_0 = 1'b0,  // instruction fetch
        MASTER_1 = 1'b1   // data access
    } master_id_e;

    // One master's view of the bus request it is presenting.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
        logic              rd;
        logic              we;
    } bus_req_t;

    // A master is requesting whenever it drives a read or a write strobe.
    function automatic logic is_requesting(input bus_req_t req);
        return req.rd | req.we;
    endfunction

    // Round-robin pick: a lone requester wins outright; on a tie the master
    // that was not served last wins.
    function automatic master_id_e rr_pick(input logic       req0,
                                           input logic       req1,
                                           input master_id_e last);
        if (req0 && req1) begin
            return (last == MASTER_0) ? MASTER_1 : MASTER_0;
        end
        if (req1) begin
            return MASTER_1;
        end
        return MASTER_0;
    endfunction

    function automatic arb_state_e grant_state(input master_id_e id);
        return (id == MASTER_1) ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// bus_watchdog: counts granted cycles in which the slave has not acked and
// flags the cycle in which that count has reached TIMEOUT.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,   // arbiter not granting: hold the count at zero
    input  logic enable_i,  // a granted transfer is live this cycle
    input  logic ack_i,     // slave ack
    output logic expired_o
);

    // The counter is WAIT_W bits wide, so TIMEOUT is taken modulo 2**WAIT_W.
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;
    logic              at_limit;

    assign at_limit = (count_q == LIMIT);

    // Expiry only matters while a transfer is live and the slave is silent;
    // an ack arriving on the limit cycle completes the transfer normally.
    assign expired_o = enable_i && !ack_i && at_limit;

    // Next count: clear has priority, otherwise advance on each silent cycle
    // and saturate at the limit.
    always_comb begin
        // NOTE: assigning the default first keeps every path covered, so no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !ack_i && !at_limit) begin
            count_d = count_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave bus arbiter. Master-0 is instruction
// fetch, master-1 is data access. Round-robin on ties, one IDLE cycle between
// accesses, and a watchdog that force-completes a transfer the slave never acks.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    // Master 0 (instruction fetch)
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic              m0_rd_i,
    input  logic              m0_we_i,
    output logic              m0_ack_o,

    // Master 1 (data access)
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic              m1_rd_i,
    input  logic              m1_we_i,
    output logic              m1_ack_o,

    // Slave side, toward the address decoder
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic              s_rd_o,
    output logic              s_we_o,
    input  logic              s_ack_i,

    // Timeout reporting
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    bus_req_t          m0_req;
    bus_req_t          m1_req;
    bus_req_t          gnt_req;
    logic              m0_req_v;
    logic              m1_req_v;

    arb_state_e        state_q;
    master_id_e        last_q;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    master_id_e        gnt_id;
    logic              granted;
    logic              gnt_live;
    logic              timeout_hit;
    logic              complete;

    assign m0_req = '{addr: m0_addr_i, data: m0_data_i, sel: m0_sel_i,
                      rd: m0_rd_i, we: m0_we_i};
    assign m1_req = '{addr: m1_addr_i, data: m1_data_i, sel: m1_sel_i,
                      rd: m1_rd_i, we: m1_we_i};

    assign m0_req_v = is_requesting(m0_req);
    assign m1_req_v = is_requesting(m1_req);

    // Select the granted master's request; IDLE presents an all-zero request.
    always_comb begin
        gnt_req = '0;
        gnt_id  = MASTER_0;
        granted = 1'b0;
        case (state_q)
            GRANT0: begin
                gnt_req = m0_req;
                gnt_id  = MASTER_0;
                granted = 1'b1;
            end
            GRANT1: begin
                gnt_req = m1_req;
                gnt_id  = MASTER_1;
                granted = 1'b1;
            end
            default: begin
                gnt_req = '0;
                gnt_id  = MASTER_0;
                granted = 1'b0;
            end
        endcase
    end

    // Live transfer: granted and the owner still holds rd or we. A drop
    // before ack is an abort and is never acknowledged.
    assign gnt_live = granted && is_requesting(gnt_req);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!granted),
        .enable_i  (gnt_live),
        .ack_i     (s_ack_i),
        .expired_o (timeout_hit)
    );

    // Ack goes to the owner on a slave ack or a forced timeout completion.
    // A cycle in which reset is asserted never acks: the grant is dropped.
    assign complete = gnt_live && !rst && (s_ack_i || timeout_hit);

    // Slave side follows the owner combinationally; strobes drop on timeout.
    assign s_addr_o = gnt_req.addr;
    assign s_data_o = gnt_req.data;
    assign s_sel_o  = gnt_req.sel;
    assign s_rd_o   = gnt_req.rd && !timeout_hit;
    assign s_we_o   = gnt_req.we && !timeout_hit;

    // Only the owner sees ack and read data; a forced completion returns zero.
    assign m0_ack_o  = complete && (gnt_id == MASTER_0);
    assign m1_ack_o  = complete && (gnt_id == MASTER_1);
    assign m0_data_o = (granted && (gnt_id == MASTER_0) && !timeout_hit) ? s_data_i : '0;
    assign m1_data_o = (granted && (gnt_id == MASTER_1) && !timeout_hit) ? s_data_i : '0;

    // err_o is registered: it pulses in the IDLE cycle that follows the forced
    // completion, the same cycle err_addr_o first shows the offending address.
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

    // Arbitration FSM with round-robin memory and registered error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= MASTER_0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_req_v || m1_req_v) begin
                        state_q <= grant_state(rr_pick(m0_req_v, m1_req_v, last_q));
                    end
                end
                GRANT0, GRANT1: begin
                    // Ack, forced timeout or abort all end the grant; the
                    // owner counts as served in every case.
                    if (!gnt_live || s_ack_i || timeout_hit) begin
                        state_q <= IDLE;
                        last_q  <= gnt_id;
                    end
                    if (timeout_hit) begin
                        err_q      <= 1'b1;
                        err_addr_q <= gnt_req.addr;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a table of per-cycle vectors covering
// single access, round-robin tie-break and a write with a competing master,
// followed by hand-written sequences for timeout, ack on the limit cycle,
// reset mid-transfer and abort.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic [1:0]  m0_sel_i;
    logic        m0_rd_i, m0_we_i, m0_ack_o;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic [1:0]  m1_sel_i;
    logic        m1_rd_i, m1_we_i, m1_ack_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic [1:0]  s_sel_o;
    logic        s_rd_o, s_we_o, s_ack_i;
    logic        err_o;
    logic [31:0] err_addr_o;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_addr_i  (m0_addr_i),
        .m0_data_i  (m0_data_i),
        .m0_data_o  (m0_data_o),
        .m0_sel_i   (m0_sel_i),
        .m0_rd_i    (m0_rd_i),
        .m0_we_i    (m0_we_i),
        .m0_ack_o   (m0_ack_o),
        .m1_addr_i  (m1_addr_i),
        .m1_data_i  (m1_data_i),
        .m1_data_o  (m1_data_o),
        .m1_sel_i   (m1_sel_i),
        .m1_rd_i    (m1_rd_i),
        .m1_we_i    (m1_we_i),
        .m1_ack_o   (m1_ack_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_data_i   (s_data_i),
        .s_sel_o    (s_sel_o),
        .s_rd_o     (s_rd_o),
        .s_we_o     (s_we_o),
        .s_ack_i    (s_ack_i),
        .err_o      (err_o),
        .err_addr_o (err_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // One cycle of stimulus and the outputs expected at that cycle's negedge.
    typedef struct {
        logic        rst;
        logic [1:0]  m0_rw;     // {rd, we}
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic [1:0]  m1_rw;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        s_ack;
        logic [31:0] s_rdata;
        logic [1:0]  e_s_rw;    // {s_rd_o, s_we_o}
        logic [31:0] e_s_addr;
        logic [31:0] e_s_wdata;
        logic [1:0]  e_s_sel;
        logic [1:0]  e_acks;    // {m1_ack_o, m0_ack_o}
        logic [31:0] e_m0_data;
        logic [31:0] e_m1_data;
        logic        e_err;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    localparam logic [1:0]  NO  = 2'b00;
    localparam logic [1:0]  RD  = 2'b10;
    localparam logic [1:0]  WR  = 2'b01;
    localparam logic [1:0]  AN  = 2'b00;
    localparam logic [1:0]  A0  = 2'b01;
    localparam logic [1:0]  A1  = 2'b10;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic [31:0] IDL = 32'hDEAD_0000;  // junk slave data while idle
    localparam logic [31:0] AF  = 32'hFFFF_F000;
    localparam logic [31:0] W0  = 32'h7E57_0000;
    localparam logic [31:0] A100 = 32'h0000_0100;
    localparam logic [31:0] A200 = 32'h0000_0200;
    localparam logic [31:0] A010 = 32'h0000_0010;
    localparam logic [31:0] AFE  = 32'hFFFF_FE0C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst       = 1'b0;
        m0_rd_i   = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m1_rd_i   = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
        s_ack_i   = 1'b0; s_data_i = '0;
    endtask

    task automatic fill_table();
        // Reset state, nothing requesting.
        tbl[0]  = '{1'b0, NO,Z,Z,     NO,Z,Z,       1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        // m0 reads 0xFFFF_F000 alone; slave acks on the 3rd granted cycle.
        tbl[1]  = '{1'b0, RD,AF,W0,   NO,Z,Z,       1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        tbl[2]  = '{1'b0, RD,AF,W0,   NO,Z,Z,       1'b0,32'hCCCC_0001, RD,AF,W0,2'b11,   AN,32'hCCCC_0001,Z, 1'b0};
        tbl[3]  = '{1'b0, RD,AF,W0,   NO,Z,Z,       1'b0,32'h1111_2222, RD,AF,W0,2'b11,   AN,32'h1111_2222,Z, 1'b0};
        tbl[4]  = '{1'b0, RD,AF,W0,   NO,Z,Z,       1'b1,32'h1234_5678, RD,AF,W0,2'b11,   A0,32'h1234_5678,Z, 1'b0};
        tbl[5]  = '{1'b0, NO,AF,W0,   NO,Z,Z,       1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        // Reset, then a tie: m1 wins first, m0 follows after one IDLE cycle.
        tbl[6]  = '{1'b1, NO,Z,Z,     NO,Z,Z,       1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        tbl[7]  = '{1'b0, RD,A100,Z,  RD,A200,Z,    1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        tbl[8]  = '{1'b0, RD,A100,Z,  RD,A200,Z,    1'b0,32'h3333_0000, RD,A200,Z,2'b10,  AN,Z,32'h3333_0000, 1'b0};
        tbl[9]  = '{1'b0, RD,A100,Z,  RD,A200,Z,    1'b1,32'hAAAA_5555, RD,A200,Z,2'b10,  A1,Z,32'hAAAA_5555, 1'b0};
        tbl[10] = '{1'b0, RD,A100,Z,  NO,Z,Z,       1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        tbl[11] = '{1'b0, RD,A100,Z,  NO,Z,Z,       1'b1,32'h0BAD_F00D, RD,A100,Z,2'b11,  A0,32'h0BAD_F00D,Z, 1'b0};
        tbl[12] = '{1'b0, NO,Z,Z,     NO,Z,Z,       1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        // m1 writes 0x41 to 0xFFFF_FE0C while m0 holds a read for 10 cycles.
        tbl[13] = '{1'b0, RD,A010,Z,  WR,AFE,32'h41, 1'b0,IDL,          NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        for (int i = 14; i <= 18; i++) begin
            tbl[i] = '{1'b0, RD,A010,Z, WR,AFE,32'h41, 1'b0,Z,          WR,AFE,32'h41,2'b10, AN,Z,Z, 1'b0};
        end
        tbl[19] = '{1'b0, RD,A010,Z,  WR,AFE,32'h41, 1'b1,Z,            WR,AFE,32'h41,2'b10, A1,Z,Z, 1'b0};
        tbl[20] = '{1'b0, RD,A010,Z,  NO,Z,Z,       1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
        tbl[21] = '{1'b0, RD,A010,Z,  NO,Z,Z,       1'b0,32'h5555_0000, RD,A010,Z,2'b11,  AN,32'h5555_0000,Z, 1'b0};
        tbl[22] = '{1'b0, RD,A010,Z,  NO,Z,Z,       1'b1,32'hCAFE_0001, RD,A010,Z,2'b11,  A0,32'hCAFE_0001,Z, 1'b0};
        tbl[23] = '{1'b0, NO,Z,Z,     NO,Z,Z,       1'b0,IDL,           NO,Z,Z,2'b00,     AN,Z,Z, 1'b0};
    endtask

    initial begin
        int ack_at;
        int early;

        fill_table();
        drive_idle();
        m0_sel_i = 2'b11;
        m1_sel_i = 2'b10;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("reset.err_o", {31'b0, err_o}, 32'h0);
        check("reset.err_addr", err_addr_o, 32'h0);
        step();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            rst       = tbl[i].rst;
            {m0_rd_i, m0_we_i} = tbl[i].m0_rw;
            m0_addr_i = tbl[i].m0_addr;
            m0_data_i = tbl[i].m0_wdata;
            {m1_rd_i, m1_we_i} = tbl[i].m1_rw;
            m1_addr_i = tbl[i].m1_addr;
            m1_data_i = tbl[i].m1_wdata;
            s_ack_i   = tbl[i].s_ack;
            s_data_i  = tbl[i].s_rdata;
            @(negedge clk);
            check($sformatf("row%0d.s_rw", i),   {30'b0, s_rd_o, s_we_o},     {30'b0, tbl[i].e_s_rw});
            check($sformatf("row%0d.s_addr", i), s_addr_o,                    tbl[i].e_s_addr);
            check($sformatf("row%0d.s_data", i), s_data_o,                    tbl[i].e_s_wdata);
            check($sformatf("row%0d.s_sel", i),  {30'b0, s_sel_o},            {30'b0, tbl[i].e_s_sel});
            check($sformatf("row%0d.acks", i),   {30'b0, m1_ack_o, m0_ack_o}, {30'b0, tbl[i].e_acks});
            check($sformatf("row%0d.m0_data", i), m0_data_o,                  tbl[i].e_m0_data);
            check($sformatf("row%0d.m1_data", i), m1_data_o,                  tbl[i].e_m1_data);
            check($sformatf("row%0d.err", i),    {31'b0, err_o},              {31'b0, tbl[i].e_err});
            step();
        end
        drive_idle();

        // ---------------- timeout on m1 read of 0x8000_0000 ----------------
        m1_rd_i   = 1'b1;
        m1_addr_i = 32'h8000_0000;
        s_data_i  = 32'h5A5A_5A5A;
        step();                         // IDLE cycle done, now granted cycle 0
        ack_at = -1;
        early  = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (err_o) early++;
            if (m1_ack_o || m0_ack_o) begin
                ack_at = k;
                break;
            end
            step();
        end
        check("timeout.ack_cycle", ack_at, 255);
        check("timeout.no_early_err", early, 0);
        check("timeout.m1_ack", {31'b0, m1_ack_o}, 32'h1);
        check("timeout.m0_ack", {31'b0, m0_ack_o}, 32'h0);
        check("timeout.m1_data", m1_data_o, 32'h0);
        check("timeout.s_rw", {30'b0, s_rd_o, s_we_o}, 32'h0);
        step();
        m1_rd_i = 1'b0;
        @(negedge clk);
        check("timeout.err_pulse", {31'b0, err_o}, 32'h1);
        check("timeout.err_addr", err_addr_o, 32'h8000_0000);
        check("timeout.idle_addr", s_addr_o, 32'h0);
        step();
        @(negedge clk);
        check("timeout.err_once", {31'b0, err_o}, 32'h0);
        check("timeout.err_addr_held", err_addr_o, 32'h8000_0000);
        step();

        // ---------------- ack arrives on the limit cycle ----------------
        m0_rd_i   = 1'b1;
        m0_addr_i = 32'h0000_0044;
        s_data_i  = 32'h5A5A_5A5A;
        step();                         // now granted cycle 0
        early = 0;
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            if (m0_ack_o || m1_ack_o || err_o) early++;
            step();
        end
        s_ack_i  = 1'b1;
        s_data_i = 32'h0000_0077;
        @(negedge clk);
        check("limit.no_early", early, 0);
        check("limit.m0_ack", {31'b0, m0_ack_o}, 32'h1);
        check("limit.m0_data", m0_data_o, 32'h0000_0077);
        check("limit.s_rd", {31'b0, s_rd_o}, 32'h1);
        step();
        m0_rd_i = 1'b0;
        s_ack_i = 1'b0;
        @(negedge clk);
        check("limit.no_err", {31'b0, err_o}, 32'h0);
        check("limit.err_addr_kept", err_addr_o, 32'h8000_0000);
        step();

        // ---------------- reset during GRANT0 ----------------
        m0_rd_i   = 1'b1;
        m0_addr_i = 32'h0000_1000;
        m0_data_i = 32'h0000_00AB;
        step();                         // granted
        @(negedge clk);
        check("rstmid.granted", {31'b0, s_rd_o}, 32'h1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.no_ack_in_rst", {31'b0, m0_ack_o}, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.s_rw", {30'b0, s_rd_o, s_we_o}, 32'h0);
        check("rstmid.s_addr", s_addr_o, 32'h0);
        check("rstmid.s_data", s_data_o, 32'h0);
        check("rstmid.s_sel", {30'b0, s_sel_o}, 32'h0);
        check("rstmid.m0_ack", {31'b0, m0_ack_o}, 32'h0);
        check("rstmid.err_addr", err_addr_o, 32'h0);
        m0_rd_i = 1'b0;
        step();

        // ---------------- abort by m0 with m1 pending ----------------
        m0_rd_i   = 1'b1;
        m0_addr_i = 32'h0000_2000;
        step();                         // granted cycle 1 to m0
        m1_rd_i   = 1'b1;
        m1_addr_i = 32'h0000_3000;
        @(negedge clk);
        check("abort.grant_kept", s_addr_o, 32'h0000_2000);
        step();                         // granted cycle 2: m0 drops rd
        m0_rd_i = 1'b0;
        @(negedge clk);
        check("abort.no_ack", {30'b0, m1_ack_o, m0_ack_o}, 32'h0);
        step();
        @(negedge clk);
        check("abort.idle_rd", {31'b0, s_rd_o}, 32'h0);
        check("abort.idle_addr", s_addr_o, 32'h0);
        step();
        s_ack_i  = 1'b1;
        s_data_i = 32'h0000_0099;
        @(negedge clk);
        check("abort.m1_addr", s_addr_o, 32'h0000_3000);
        check("abort.m1_ack", {30'b0, m1_ack_o, m0_ack_o}, 32'h2);
        check("abort.m1_data", m1_data_o, 32'h0000_0099);
        step();
        drive_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
